// File: rtl/code_prefetch_queue.sv
// code_prefetch_queue: byte-granular instruction prefetch queue fed by dword code fetches
// Ports: clock/reset (async active-low); flush/flush_eip restart fetching at a new EIP;
// fetch_req/fetch_addr/fetch_ack/fetch_data form the code-fetch bus; head_data/head_count
// present the oldest bytes at decode_eip; consume removes bytes; queue_count is the fill level.
module code_prefetch_queue #(
  parameter int QUEUE_BYTES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_eip,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] head_data,
  output logic [2:0]  head_count,
  input  logic [2:0]  consume,
  output logic [31:0] decode_eip,
  output logic [4:0]  queue_count
);
  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
  state_t state, state_n;
  logic [7:0] mem [QUEUE_BYTES];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [29:0] fetch_ptr, fetch_ptr_n;
  logic [1:0] skip;
  logic ack_fetch, has_space;
  logic [2:0] eff, wr_n;
  assign queue_count = 5'(count);
  assign has_space = count <= CW'(QUEUE_BYTES - 4);
  assign ack_fetch = state == FETCH && fetch_ack && !flush;
  assign head_count = count >= CW'(4) ? 3'd4 : 3'(count);
  assign eff = flush ? 3'd0 : (consume < head_count ? consume : head_count);
  assign wr_n = ack_fetch ? 3'd4 - {1'b0, skip} : 3'd0;
  assign fetch_ptr_n = flush ? flush_eip[31:2] : ack_fetch ? fetch_ptr + 30'd1 : fetch_ptr;
  // A flush never withdraws an outstanding request: it is parked in DISCARD until acked.
  assign state_n = flush ? ((state == IDLE || fetch_ack) ? IDLE : DISCARD)
                 : state == IDLE ? (has_space ? FETCH : IDLE)
                 : fetch_ack ? IDLE : state;
  always_comb begin
    head_data = '0;
    for (int i = 0; i < 4; i++)
      head_data[8*i +: 8] = CW'(i) < count ? mem[rd_ptr + PW'(i)] : 8'h00;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_req  <= 1'b0;
      fetch_addr <= '0;
      fetch_ptr  <= '0;
      skip       <= '0;
      decode_eip <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      state      <= state_n;
      fetch_req  <= state_n != IDLE;
      fetch_addr <= state_n == DISCARD ? fetch_addr : {fetch_ptr_n, 2'b00};
      fetch_ptr  <= fetch_ptr_n;
      skip       <= flush ? flush_eip[1:0] : ack_fetch ? 2'd0 : skip;
      decode_eip <= flush ? flush_eip : decode_eip + 32'(eff);
      rd_ptr     <= flush ? '0 : rd_ptr + PW'(eff);
      wr_ptr     <= flush ? '0 : wr_ptr + PW'(wr_n);
      count      <= flush ? '0 : count - CW'(eff) + CW'(wr_n);
    end
  end
  // Bytes below skip precede the branch target within the dword and are never queued.
  always_ff @(posedge clock) begin
    if (ack_fetch)
      for (int k = 0; k < 4; k++)
        if (2'(k) >= skip) mem[wr_ptr + PW'(k) - PW'(skip)] <= fetch_data[8*k +: 8];
  end
endmodule

// File: tb/tb_code_prefetch_queue.sv
// tb_code_prefetch_queue: directed and randomized checks of code_prefetch_queue against a byte-queue model
module tb_code_prefetch_queue;
  localparam int QB = 16;
  logic clock, reset, flush, fetch_req, fetch_ack;
  logic [31:0] flush_eip, fetch_addr, fetch_data, head_data, decode_eip;
  logic [2:0] head_count, consume;
  logic [4:0] queue_count;
  int total = 0, passes = 0;
  logic [7:0] m_q[$];
  logic [31:0] m_eip, m_ptr, m_addr;
  int m_skip;
  bit m_req, m_disc;

  code_prefetch_queue #(.QUEUE_BYTES(QB)) dut (
    .clock(clock), .reset(reset), .flush(flush), .flush_eip(flush_eip),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .head_data(head_data), .head_count(head_count),
    .consume(consume), .decode_eip(decode_eip), .queue_count(queue_count)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_q.delete();
    m_eip = 0; m_ptr = 0; m_addr = 0; m_skip = 0; m_req = 0; m_disc = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then wait past the edge.
  task automatic step(input logic f, input logic [31:0] fe, input logic a,
                      input logic [31:0] d, input logic [2:0] c);
    int n, hc, e;
    flush = f; flush_eip = fe; fetch_ack = a; fetch_data = d; consume = c;
    n = m_q.size();
    hc = n < 4 ? n : 4;
    e = int'(c) < hc ? int'(c) : hc;
    if (f) begin
      m_q.delete();
      m_eip = fe; m_ptr = {fe[31:2], 2'b00}; m_skip = int'(fe[1:0]);
      if (m_req) begin
        if (a) begin m_req = 0; m_disc = 0; end
        else m_disc = 1;
      end
    end else begin
      repeat (e) void'(m_q.pop_front());
      m_eip = m_eip + e;
      if (m_req && a) begin
        if (!m_disc) begin
          for (int k = m_skip; k < 4; k++) m_q.push_back(d[8*k +: 8]);
          m_ptr = m_ptr + 4; m_skip = 0;
        end
        m_req = 0; m_disc = 0;
      end else if (!m_req && QB - n >= 4) begin
        m_req = 1; m_addr = m_ptr;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_req(input string name);
    for (int t = 0; t < 8 && !fetch_req; t++) idle();
    total++;
    if (fetch_req !== 1'b1) $display("FAIL %s_req_timeout got %b exp 1", name, fetch_req);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 0; flush = 0; flush_eip = 0; fetch_ack = 0; fetch_data = 0; consume = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    total += 6;
    if (fetch_req !== 1'b0) $display("FAIL rst_req got %b exp 0", fetch_req); else passes++;
    if (fetch_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", fetch_addr); else passes++;
    if (decode_eip !== 32'h0) $display("FAIL rst_eip got %h exp 0", decode_eip); else passes++;
    if (queue_count !== 5'd0) $display("FAIL rst_count got %0d exp 0", queue_count); else passes++;
    if (head_count !== 3'd0) $display("FAIL rst_hcount got %0d exp 0", head_count); else passes++;
    if (head_data !== 32'h0) $display("FAIL rst_hdata got %h exp 0", head_data); else passes++;
    reset = 1;
    total++;
    if (fetch_req !== 1'b0) $display("FAIL first_cycle_req got %b exp 0", fetch_req); else passes++;
    idle();
    total += 2;
    if (fetch_req !== 1'b1) $display("FAIL second_cycle_req got %b exp 1", fetch_req); else passes++;
    if (fetch_addr !== 32'h0) $display("FAIL second_cycle_addr got %h exp 0", fetch_addr); else passes++;
  endtask

  task automatic test_fill();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      wait_req("fill");
      a = 32'(4 * i);
      total++;
      if (fetch_addr !== a) $display("FAIL fill_addr%0d got %h exp %h", i, fetch_addr, a); else passes++;
      step(0, 0, 1, {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]}, 0);
    end
    repeat (3) idle();
    total += 3;
    if (fetch_req !== 1'b0) $display("FAIL full_stall_req got %b exp 0", fetch_req); else passes++;
    if (queue_count !== 5'd16) $display("FAIL full_count got %0d exp 16", queue_count); else passes++;
    if (head_data !== 32'h03020100) $display("FAIL full_head got %h exp 03020100", head_data); else passes++;
  endtask

  task automatic test_consume_full();
    step(0, 0, 0, 0, 4);
    total += 2;
    if (queue_count !== 5'd12) $display("FAIL cons_count got %0d exp 12", queue_count); else passes++;
    if (decode_eip !== 32'd4) $display("FAIL cons_eip got %h exp 4", decode_eip); else passes++;
    idle();
    total += 2;
    if (fetch_req !== 1'b1) $display("FAIL refetch_req got %b exp 1", fetch_req); else passes++;
    if (fetch_addr !== 32'd16) $display("FAIL refetch_addr got %h exp 10", fetch_addr); else passes++;
    step(0, 0, 1, 32'h13121110, 0);
    total += 2;
    if (queue_count !== 5'd16) $display("FAIL refill_count got %0d exp 16", queue_count); else passes++;
    if (head_data !== 32'h07060504) $display("FAIL refill_head got %h exp 07060504", head_data); else passes++;
  endtask

  task automatic test_flush_misaligned();
    step(1, 32'h00001003, 0, 0, 4);
    total++;
    if (queue_count !== 5'd0) $display("FAIL flush_count got %0d exp 0", queue_count); else passes++;
    wait_req("mis");
    total++;
    if (fetch_addr !== 32'h1000) $display("FAIL mis_addr got %h exp 1000", fetch_addr); else passes++;
    step(0, 0, 1, 32'hDDCCBBAA, 0);
    total += 4;
    if (queue_count !== 5'd1) $display("FAIL mis_count got %0d exp 1", queue_count); else passes++;
    if (head_count !== 3'd1) $display("FAIL mis_hcount got %0d exp 1", head_count); else passes++;
    if (head_data !== 32'h000000DD) $display("FAIL mis_head got %h exp 000000dd", head_data); else passes++;
    if (decode_eip !== 32'h1003) $display("FAIL mis_eip got %h exp 1003", decode_eip); else passes++;
  endtask

  task automatic test_over_consume();
    step(1, 32'h00002002, 0, 0, 0);
    wait_req("over");
    step(0, 0, 1, 32'h44332211, 0);
    total++;
    if (head_data !== 32'h00004433) $display("FAIL over_head got %h exp 00004433", head_data); else passes++;
    step(0, 0, 0, 0, 4);
    total += 4;
    if (queue_count !== 5'd0) $display("FAIL over_count got %0d exp 0", queue_count); else passes++;
    if (head_count !== 3'd0) $display("FAIL over_hcount got %0d exp 0", head_count); else passes++;
    if (head_data !== 32'h0) $display("FAIL over_hdata got %h exp 0", head_data); else passes++;
    if (decode_eip !== 32'h2004) $display("FAIL over_eip got %h exp 2004", decode_eip); else passes++;
  endtask

  task automatic test_flush_during_fetch();
    total += 2;
    if (fetch_req !== 1'b1) $display("FAIL pend_req got %b exp 1", fetch_req); else passes++;
    if (fetch_addr !== 32'h2004) $display("FAIL pend_addr got %h exp 2004", fetch_addr); else passes++;
    step(1, 32'h00003000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      total += 2;
      if (fetch_req !== 1'b1) $display("FAIL disc_req%0d got %b exp 1", i, fetch_req); else passes++;
      if (fetch_addr !== 32'h2004) $display("FAIL disc_addr%0d got %h exp 2004", i, fetch_addr); else passes++;
      idle();
    end
    step(0, 0, 1, 32'hEEEEEEEE, 0);
    total += 2;
    if (queue_count !== 5'd0) $display("FAIL disc_drop got %0d exp 0", queue_count); else passes++;
    if (fetch_req !== 1'b0) $display("FAIL disc_end_req got %b exp 0", fetch_req); else passes++;
    idle();
    total++;
    if (fetch_addr !== 32'h3000 || fetch_req !== 1'b1)
      $display("FAIL target_addr got %h/%b exp 3000/1", fetch_addr, fetch_req);
    else passes++;
    step(0, 0, 1, 32'h03020100, 0);
  endtask

  task automatic test_wrap();
    step(1, 32'hFFFFFFFC, 0, 0, 0);
    wait_req("wrap0");
    total++;
    if (fetch_addr !== 32'hFFFFFFFC) $display("FAIL wrap_addr0 got %h exp fffffffc", fetch_addr); else passes++;
    step(0, 0, 1, 32'h0B0A0908, 0);
    wait_req("wrap1");
    total++;
    if (fetch_addr !== 32'h0) $display("FAIL wrap_addr1 got %h exp 0", fetch_addr); else passes++;
    step(0, 0, 1, 32'h0F0E0D0C, 0);
    total += 2;
    if (queue_count !== 5'd8) $display("FAIL wrap_count got %0d exp 8", queue_count); else passes++;
    if (decode_eip !== 32'hFFFFFFFC) $display("FAIL wrap_eip got %h exp fffffffc", decode_eip); else passes++;
  endtask

  task automatic test_reset_mid_fetch();
    idle();
    total++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h4)
      $display("FAIL midrst_pre got %b/%h exp 1/4", fetch_req, fetch_addr);
    else passes++;
    reset = 0;
    #2;
    total += 2;
    if (fetch_req !== 1'b0) $display("FAIL midrst_req got %b exp 0", fetch_req); else passes++;
    if (queue_count !== 5'd0) $display("FAIL midrst_count got %0d exp 0", queue_count); else passes++;
    model_reset();
    @(posedge clock); #1;
    reset = 1;
    idle();
    total++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h0)
      $display("FAIL midrst_restart got %b/%h exp 1/0", fetch_req, fetch_addr);
    else passes++;
  endtask

  task automatic test_random();
    logic [31:0] exp_head;
    int n;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(15) == 0, $urandom, $urandom_range(1), $urandom, 3'($urandom_range(4)));
      n = m_q.size();
      exp_head = 0;
      for (int j = 0; j < 4 && j < n; j++) exp_head[8*j +: 8] = m_q[j];
      total += 5;
      if (fetch_req !== m_req) $display("FAIL rnd_req@%0d got %b exp %b", i, fetch_req, m_req); else passes++;
      if (queue_count !== 5'(n)) $display("FAIL rnd_count@%0d got %0d exp %0d", i, queue_count, n); else passes++;
      if (head_count !== 3'(n < 4 ? n : 4)) $display("FAIL rnd_hcount@%0d got %0d exp %0d", i, head_count, n < 4 ? n : 4); else passes++;
      if (head_data !== exp_head) $display("FAIL rnd_head@%0d got %h exp %h", i, head_data, exp_head); else passes++;
      if (decode_eip !== m_eip) $display("FAIL rnd_eip@%0d got %h exp %h", i, decode_eip, m_eip); else passes++;
      if (m_req) begin
        total++;
        if (fetch_addr !== m_addr) $display("FAIL rnd_addr@%0d got %h exp %h", i, fetch_addr, m_addr); else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_consume_full();
    test_flush_misaligned();
    test_over_consume();
    test_flush_during_fetch();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/code_prefetch_queue.md
CODE_PREFETCH_QUEUE -- requirements
Module: code_prefetch_queue

Interface
REQ-001 The block SHALL have one parameter: QUEUE_BYTES, default 16, queue depth in bytes (power of two, at least 8).
REQ-002 clock  input  1  rising-edge clock; reset reset, asynchronous, active-low; clock clock.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  control transfer: discard the queue and restart fetching at flush_eip.
REQ-005 flush_eip  input  32  new EIP, sampled when flush=1.
REQ-006 fetch_req  output  1  code-fetch bus request.
REQ-007 fetch_addr  output  32  dword-aligned fetch address; bits [1:0] are always 0.
REQ-008 fetch_ack  input  1  bus accepts the request; fetch_data is valid in the same cycle.
REQ-009 fetch_data  input  32  fetched dword, little-endian; [7:0] is the byte at fetch_addr.
REQ-010 head_data  output  32  up to 4 oldest queued bytes; [7:0] is the byte at decode_eip.
REQ-011 head_count  output  3  valid bytes in head_data, equal to min(count, 4).
REQ-012 consume  input  3  bytes the decoder removes this cycle (0-4).
REQ-013 decode_eip  output  32  EIP of the head byte.
REQ-014 queue_count  output  5  bytes currently queued, in the range 0 to QUEUE_BYTES.

Function
REQ-015 Storage SHALL be a circular byte buffer with read and write pointers taken modulo QUEUE_BYTES.
REQ-016 The fetch FSM SHALL have three states: IDLE, FETCH and DISCARD.
REQ-017 IDLE -> FETCH when flush=0 and free space (QUEUE_BYTES - queue_count, from registered values) is at least 4; otherwise stay in IDLE.
REQ-018 fetch_req SHALL be 1 exactly in FETCH and DISCARD.
REQ-019 fetch_addr SHALL equal fetch_ptr and SHALL remain stable until fetch_ack.
REQ-020 FETCH with fetch_ack=1 and flush=0:
- write fetch_data bytes skip..3 into the queue, in byte order, where skip is the pending misalignment;
- set fetch_ptr to fetch_ptr+4;
- clear skip to 0;
- go to IDLE.
REQ-021 FETCH with flush=1 and fetch_ack=0 -> DISCARD. The outstanding request is never withdrawn.
REQ-022 DISCARD SHALL hold fetch_req=1 with the old fetch_addr; on fetch_ack, drop the data and go to IDLE.
REQ-023 flush in any state SHALL, at the next edge:
- set decode_eip to flush_eip;
- set fetch_ptr to {flush_eip[31:2], 2'b00};
- set skip to flush_eip[1:0];
- set queue_count to 0;
- ignore consume in that cycle.
REQ-024 flush together with fetch_ack in FETCH or DISCARD SHALL drop the data, apply REQ-023 and go to IDLE.
REQ-025 Effective consume SHALL be min(consume, head_count).
REQ-026 Effective consume SHALL advance the read pointer and decode_eip (mod 2^32) by that amount in the same cycle.
REQ-027 A simultaneous write and consume SHALL give queue_count_next = queue_count - consumed + written; the queue can never overflow.
REQ-028 head_data byte lanes at or above head_count SHALL read 0.
REQ-029 head_data, head_count, queue_count and decode_eip SHALL come directly from registered state, with no combinational path from consume or fetch_ack.
REQ-030 Bytes written at an edge SHALL be visible on head_data in the next cycle (1-cycle latency from fetch_ack).
REQ-031 fetch_ptr SHALL wrap from 0xFFFFFFFC to 0x00000000.

Reset
REQ-032 While reset=0, the block SHALL hold:
- state = IDLE;
- fetch_req = 0 and fetch_addr = 0;
- decode_eip = 0;
- skip = 0;
- queue_count = 0;
- head_count = 0 and head_data = 0.
REQ-033 Reset asserted mid-fetch SHALL abandon the request immediately with no DISCARD.
REQ-034 The first fetch_req SHALL rise in the second cycle after reset deasserts.

Verification
REQ-035 Reset, then ack each request with the dword whose byte value equals its address. Required response:
- fetch_addr sequence is 0, 4, 8, 12;
- fetch stalls with queue_count=16 while consume=0.
REQ-036 flush with flush_eip=0x00001003, ack with fetch_data=0xDDCCBBAA. Required response:
- fetch_addr=0x00001000;
- queue_count=1, head_data=0x000000DD, decode_eip=0x00001003.
REQ-037 Queue full (16 bytes), consume=4 for one cycle, then ack. Required response:
- decode_eip advances by 4;
- a new fetch issues;
- queue_count goes 16 -> 12 -> 16.
REQ-038 flush while in FETCH, with ack withheld for 3 cycles. Required response:
- fetch_req stays 1 with the old address;
- the acked data is dropped;
- the next fetch_addr is the flush target.
REQ-039 queue_count=2, consume=4. Required response:
- only 2 bytes are removed;
- queue_count=0, head_count=0;
- decode_eip advances by 2.
REQ-040 flush_eip=0xFFFFFFFC with two acks. Required response: fetch_addr sequence is 0xFFFFFFFC, then 0x00000000.
